// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: branch condition codes,
// load/store width codes, FSM state encoding and small decode helpers.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        COND_NEVER   = 3'b000,
        COND_ZERO    = 3'b001,
        COND_NZERO   = 3'b010,
        COND_LESS    = 3'b011,
        COND_NLESS   = 3'b100,
        COND_GT      = 3'b101,
        COND_LE      = 3'b110,
        COND_NEVER_B = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        LT_WORD   = 2'b00,
        LT_BYTE_S = 2'b01,
        LT_BYTE_U = 2'b10,
        LT_HALF_S = 2'b11
    } load_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Branch condition evaluation from the ALU flags.
    function automatic logic cond_taken(input logic [2:0] cond,
                                        input logic zero,
                                        input logic less);
        logic taken;
        case (cond)
            COND_ZERO:  taken = zero;
            COND_NZERO: taken = ~zero;
            COND_LESS:  taken = less;
            COND_NLESS: taken = ~less;
            COND_GT:    taken = ~less & ~zero;
            COND_LE:    taken = less | zero;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Word accesses need a 4-byte boundary, halfword accesses a 2-byte one.
    function automatic logic misaligned(input logic [1:0] lt,
                                        input logic [1:0] lb);
        logic err;
        case (lt)
            LT_WORD:   err = (lb != 2'b00);
            LT_HALF_S: err = lb[0];
            default:   err = 1'b0;
        endcase
        return err;
    endfunction

    // Byte-lane enables for the selected access width and offset.
    function automatic logic [3:0] byte_enables(input logic [1:0] lt,
                                                input logic [1:0] lb);
        logic [3:0] be;
        case (lt)
            LT_WORD:   be = 4'b1111;
            LT_HALF_S: be = 4'b0011 << lb;
            default:   be = 4'b0001 << lb;
        endcase
        return be;
    endfunction

    // Replicate the low byte/halfword so any enabled lane carries the data.
    function automatic logic [31:0] lane_replicate(input logic [1:0] lt,
                                                   input logic [31:0] sd);
        logic [31:0] wd;
        case (lt)
            LT_WORD:   wd = sd;
            LT_HALF_S: wd = {2{sd[15:0]}};
            default:   wd = {4{sd[7:0]}};
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed lane out of the read word and
// sign- or zero-extends it to 32 bits according to the load type.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  load_type_i,
    input  logic [1:0]  load_byte_i,
    output logic [31:0] data_o
);

    logic [15:0] lane_s;

    // Shift the addressed byte down to bit 0, then extend per load type.
    always_comb begin
        lane_s = 16'(rdata_i >> {load_byte_i, 3'b000});
        data_o = rdata_i;
        case (load_type_i)
            LT_WORD:   data_o = rdata_i;
            LT_BYTE_S: data_o = {{24{lane_s[7]}}, lane_s[7:0]};
            LT_BYTE_U: data_o = {24'h000000, lane_s[7:0]};
            LT_HALF_S: data_o = {{16{lane_s[15]}}, lane_s};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: resolves branch/jump redirects, issues data-memory
// requests with a two-state wait FSM, stalls upstream while a request is
// outstanding, and registers the MEM/WB results on the falling clock edge.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] PC_Branch_in,
    input  logic [31:0] PC_Jump_in,
    input  logic [31:0] ALUShift_out_in,
    input  logic        Jump_in,
    input  logic        Less_in,
    input  logic        Zero_in,
    input  logic        Overflow_in,
    input  logic [2:0]  Condition_in,
    input  logic [1:0]  LoadType_in,
    input  logic [1:0]  LoadByte_in,
    input  logic        RegWr_in,
    input  logic        MemWr_in,
    input  logic        MemtoReg_in,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] Store_data_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        PC_Src,
    output logic [31:0] PC_Target,
    output logic        Stall,
    output logic        Addr_err,
    output logic        RegWr_wb,
    output logic [4:0]  Rd_wb,
    output logic [31:0] WbData_wb
);

    state_e      state_q, state_d;
    logic        access_s;
    logic        req_s;
    logic [31:0] load_data_s;
    logic        regwr_q, regwr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wbdata_q, wbdata_d;

    load_align u_load_align (
        .rdata_i     (mem_rdata),
        .load_type_i (LoadType_in),
        .load_byte_i (LoadByte_in),
        .data_o      (load_data_s)
    );

    // Redirect decode; an unconditional jump overrides any branch target.
    always_comb begin
        PC_Src = Jump_in | cond_taken(Condition_in, Zero_in, Less_in);
        if (Jump_in) begin
            PC_Target = PC_Jump_in;
        end else begin
            PC_Target = PC_Branch_in;
        end
    end

    // Access qualification and memory-side address/lane/data formatting.
    // Overflowing or misaligned operations never reach memory.
    always_comb begin
        Addr_err  = misaligned(LoadType_in, LoadByte_in);
        access_s  = (MemWr_in | MemtoReg_in) & ~Addr_err & ~Overflow_in;
        mem_addr  = {ALUShift_out_in[31:2], 2'b00};
        mem_be    = byte_enables(LoadType_in, LoadByte_in);
        mem_wdata = lane_replicate(LoadType_in, Store_data_in);
    end

    // Request FSM next state: IDLE issues and completes on a same-cycle ack,
    // WAIT keeps the request asserted until the ack arrives.
    always_comb begin
        state_d = state_q;
        req_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_s = access_s;
                if (access_s & ~mem_ack) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                req_s = 1'b1;
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                req_s   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request and stall drop immediately while reset is asserted, even if the
    // EX/MEM inputs still describe an access.
    always_comb begin
        mem_req = req_s & ~Reset;
        mem_we  = mem_req & MemWr_in;
        Stall   = mem_req & ~mem_ack;
    end

    // MEM/WB next values: a bubble while stalled, otherwise the stage result.
    always_comb begin
        regwr_d  = 1'b0;
        rd_d     = 5'd0;
        wbdata_d = 32'h0000_0000;
        if (Stall) begin
            regwr_d  = 1'b0;
            rd_d     = 5'd0;
            wbdata_d = 32'h0000_0000;
        end else begin
            regwr_d = RegWr_in & ~Overflow_in & ~Addr_err;
            rd_d    = Rd_in;
            if (MemtoReg_in) begin
                wbdata_d = load_data_s;
            end else begin
                wbdata_d = ALUShift_out_in;
            end
        end
    end

    // FSM state register, falling-edge clocked.
    always_ff @(negedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB pipeline register, falling-edge clocked.
    always_ff @(negedge clk or posedge Reset) begin
        if (Reset) begin
            regwr_q  <= 1'b0;
            rd_q     <= 5'd0;
            wbdata_q <= 32'h0000_0000;
        end else begin
            regwr_q  <= regwr_d;
            rd_q     <= rd_d;
            wbdata_q <= wbdata_d;
        end
    end

    assign RegWr_wb  = regwr_q;
    assign Rd_wb     = rd_q;
    assign WbData_wb = wbdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. Inputs change just after the rising edge,
// combinational outputs are sampled mid-high-phase and MEM/WB outputs just
// after the falling (active) edge.
module tb_mem_stage;

    logic        clk;
    logic        Reset;
    logic [31:0] PC_Branch_in, PC_Jump_in, ALUShift_out_in;
    logic        Jump_in, Less_in, Zero_in, Overflow_in;
    logic [2:0]  Condition_in;
    logic [1:0]  LoadType_in, LoadByte_in;
    logic        RegWr_in, MemWr_in, MemtoReg_in;
    logic [4:0]  Rd_in;
    logic [31:0] Store_data_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        PC_Src;
    logic [31:0] PC_Target;
    logic        Stall, Addr_err;
    logic        RegWr_wb;
    logic [4:0]  Rd_wb;
    logic [31:0] WbData_wb;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_stage dut (
        .clk(clk), .Reset(Reset),
        .PC_Branch_in(PC_Branch_in), .PC_Jump_in(PC_Jump_in),
        .ALUShift_out_in(ALUShift_out_in),
        .Jump_in(Jump_in), .Less_in(Less_in), .Zero_in(Zero_in),
        .Overflow_in(Overflow_in), .Condition_in(Condition_in),
        .LoadType_in(LoadType_in), .LoadByte_in(LoadByte_in),
        .RegWr_in(RegWr_in), .MemWr_in(MemWr_in), .MemtoReg_in(MemtoReg_in),
        .Rd_in(Rd_in), .Store_data_in(Store_data_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .PC_Src(PC_Src), .PC_Target(PC_Target),
        .Stall(Stall), .Addr_err(Addr_err),
        .RegWr_wb(RegWr_wb), .Rd_wb(Rd_wb), .WbData_wb(WbData_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_cond(input int c, input logic z, input logic l);
        case (c)
            1: return z;
            2: return !z;
            3: return l;
            4: return !l;
            5: return !l && !z;
            6: return l || z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_misal(input int lt, input logic [31:0] a);
        if (lt == 0) return (a % 4) != 0;
        if (lt == 3) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_extract(input int lt, input int off, input logic [31:0] rd);
        int unsigned v;
        v = rd >> (8 * off);
        case (lt)
            1: begin v = v % 256;   return (v >= 128)   ? v - 256   : v; end
            2: return v % 256;
            3: begin v = v % 65536; return (v >= 32768) ? v - 65536 : v; end
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input int lt, input int off);
        int v;
        v = (lt == 0) ? 15 : (lt == 3) ? (3 << off) : (1 << off);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input int lt, input logic [31:0] sd);
        if (lt == 0) return sd;
        if (lt == 3) return (sd % 65536) * 32'h0001_0001;
        return (sd % 256) * 32'h0101_0101;
    endfunction

    task automatic clear_inputs();
        PC_Branch_in = 32'h0; PC_Jump_in = 32'h0; ALUShift_out_in = 32'h0;
        Jump_in = 1'b0; Less_in = 1'b0; Zero_in = 1'b0; Overflow_in = 1'b0;
        Condition_in = 3'd0; LoadType_in = 2'd0; LoadByte_in = 2'd0;
        RegWr_in = 1'b0; MemWr_in = 1'b0; MemtoReg_in = 1'b0; Rd_in = 5'd0;
        Store_data_in = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    endtask

    // Runs the currently driven EX/MEM operation to completion, acking after
    // 'waits' stall cycles, checking every cycle against the model.
    // Entered and left at rising edge + 1.
    task automatic run_txn(input int waits, input logic [31:0] rdata, input string tag);
        logic misal, acc, last, exp_src, exp_rw;
        logic [31:0] exp_tgt, exp_wb;
        int ncyc;
        misal = m_misal(LoadType_in, ALUShift_out_in);
        acc   = (MemWr_in || MemtoReg_in) && !misal && !Overflow_in;
        ncyc  = acc ? waits + 1 : 1;
        exp_src = Jump_in || m_cond(Condition_in, Zero_in, Less_in);
        exp_tgt = Jump_in ? PC_Jump_in : PC_Branch_in;
        for (int c = 0; c < ncyc; c++) begin
            last      = (c == ncyc - 1);
            mem_ack   = acc && last;
            mem_rdata = last ? rdata : $urandom;
            #1;
            tests_run++; if (mem_req !== acc) begin tests_failed++; $display("FAIL %s mem_req got %0b exp %0b", tag, mem_req, acc); end
            tests_run++; if (Stall !== (acc && !last)) begin tests_failed++; $display("FAIL %s Stall got %0b exp %0b", tag, Stall, acc && !last); end
            tests_run++; if (Addr_err !== misal) begin tests_failed++; $display("FAIL %s Addr_err got %0b exp %0b", tag, Addr_err, misal); end
            tests_run++; if (PC_Src !== exp_src || PC_Target !== exp_tgt) begin tests_failed++; $display("FAIL %s pc got %0b/%h exp %0b/%h", tag, PC_Src, PC_Target, exp_src, exp_tgt); end
            if (acc) begin
                tests_run++; if (mem_addr !== ALUShift_out_in - (ALUShift_out_in % 4) || mem_be !== m_be(LoadType_in, ALUShift_out_in % 4) || mem_we !== MemWr_in) begin
                    tests_failed++; $display("FAIL %s addr/be/we got %h/%b/%0b exp %h/%b/%0b", tag, mem_addr, mem_be, mem_we, ALUShift_out_in - (ALUShift_out_in % 4), m_be(LoadType_in, ALUShift_out_in % 4), MemWr_in); end
                if (MemWr_in) begin
                    tests_run++; if (mem_wdata !== m_wdata(LoadType_in, Store_data_in)) begin tests_failed++; $display("FAIL %s wdata got %h exp %h", tag, mem_wdata, m_wdata(LoadType_in, Store_data_in)); end
                end
            end
            @(negedge clk); #1;
            if (!last) begin
                tests_run++; if (RegWr_wb !== 1'b0 || Rd_wb !== 5'd0 || WbData_wb !== 32'h0) begin tests_failed++; $display("FAIL %s bubble got %0b/%0d/%h exp 0/0/0", tag, RegWr_wb, Rd_wb, WbData_wb); end
            end else begin
                exp_rw = RegWr_in && !Overflow_in && !misal;
                exp_wb = MemtoReg_in ? m_extract(LoadType_in, ALUShift_out_in % 4, rdata) : ALUShift_out_in;
                tests_run++; if (RegWr_wb !== exp_rw || Rd_wb !== Rd_in) begin tests_failed++; $display("FAIL %s wb ctl got %0b/%0d exp %0b/%0d", tag, RegWr_wb, Rd_wb, exp_rw, Rd_in); end
                if (!(MemtoReg_in && misal)) begin
                    tests_run++; if (WbData_wb !== exp_wb) begin tests_failed++; $display("FAIL %s wbdata got %h exp %h", tag, WbData_wb, exp_wb); end
                end
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic set_mem(input int op, input logic [31:0] addr, input int lt);
        ALUShift_out_in = addr;
        LoadByte_in     = 2'(addr % 4);
        LoadType_in     = 2'(lt);
        MemtoReg_in     = (op == 1);
        MemWr_in        = (op == 2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        Reset = 1'b0;
        #1 Reset = 1'b1;
        set_mem(1, 32'h0000_0100, 0);
        RegWr_in = 1'b1; Rd_in = 5'd9;
        @(negedge clk); #1;
        tests_run++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin tests_failed++; $display("FAIL reset req/stall got %0b/%0b exp 0/0", mem_req, Stall); end
        tests_run++; if (RegWr_wb !== 1'b0 || Rd_wb !== 5'd0 || WbData_wb !== 32'h0) begin tests_failed++; $display("FAIL reset wb got %0b/%0d/%h exp 0/0/0", RegWr_wb, Rd_wb, WbData_wb); end
        clear_inputs();
        @(posedge clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_branch();
        clear_inputs();
        Condition_in = 3'b001; Zero_in = 1'b1; PC_Branch_in = 32'h40;
        #1;
        tests_run++; if (PC_Src !== 1'b1 || PC_Target !== 32'h40) begin tests_failed++; $display("FAIL branch_zero got %0b/%h exp 1/00000040", PC_Src, PC_Target); end
        Jump_in = 1'b1; PC_Jump_in = 32'h80;
        #1;
        tests_run++; if (PC_Src !== 1'b1 || PC_Target !== 32'h80) begin tests_failed++; $display("FAIL jump_prio got %0b/%h exp 1/00000080", PC_Src, PC_Target); end
        Jump_in = 1'b0; Condition_in = 3'b111; Less_in = 1'b1;
        #1;
        tests_run++; if (PC_Src !== 1'b0) begin tests_failed++; $display("FAIL cond_never got %0b exp 0", PC_Src); end
        for (int i = 0; i < 24; i++) begin
            Condition_in = 3'(i % 8); Zero_in = 1'(i / 8); Less_in = 1'(i / 16);
            #1;
            tests_run++; if (PC_Src !== m_cond(i % 8, 1'(i / 8), 1'(i / 16))) begin tests_failed++; $display("FAIL cond_%0d got %0b exp %0b", i, PC_Src, m_cond(i % 8, 1'(i / 8), 1'(i / 16))); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        clear_inputs();
        set_mem(1, 32'h0000_1003, 1);
        RegWr_in = 1'b1; Rd_in = 5'd7;
        run_txn(0, 32'h80FF_0011, "load_byte");
        tests_run++; if (WbData_wb !== 32'hFFFF_FF80 || RegWr_wb !== 1'b1) begin tests_failed++; $display("FAIL load_byte_const got %h/%0b exp ffffff80/1", WbData_wb, RegWr_wb); end
    endtask

    task automatic test_store_half_wait();
        clear_inputs();
        set_mem(2, 32'h0000_2002, 3);
        Store_data_in = 32'h1234_ABCD; Rd_in = 5'd5;
        #1;
        tests_run++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin tests_failed++; $display("FAIL store_half_const got %b/%h exp 1100/abcdabcd", mem_be, mem_wdata); end
        run_txn(2, 32'h0, "store_half");
        clear_inputs();
        #1;
        tests_run++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin tests_failed++; $display("FAIL store_idle got %0b/%0b exp 0/0", mem_req, Stall); end
        set_mem(1, 32'h0000_2000, 0); RegWr_in = 1'b1; Rd_in = 5'd3;
        run_txn(0, 32'hCAFE_F00D, "after_wait");
    endtask

    task automatic test_misaligned();
        clear_inputs();
        set_mem(1, 32'h0000_3001, 0);
        RegWr_in = 1'b1; Rd_in = 5'd4;
        run_txn(0, 32'h1111_1111, "misaligned");
        tests_run++; if (RegWr_wb !== 1'b0) begin tests_failed++; $display("FAIL misaligned_rw got %0b exp 0", RegWr_wb); end
        clear_inputs();
        ALUShift_out_in = 32'h7FFF_FFF0; Overflow_in = 1'b1; RegWr_in = 1'b1; Rd_in = 5'd8;
        run_txn(0, 32'h0, "overflow");
        tests_run++; if (RegWr_wb !== 1'b0) begin tests_failed++; $display("FAIL overflow_rw got %0b exp 0", RegWr_wb); end
    endtask

    task automatic test_reset_wait();
        clear_inputs();
        set_mem(2, 32'h0000_4000, 0);
        Store_data_in = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (Stall !== 1'b1) begin tests_failed++; $display("FAIL rstwait_pre got %0b exp 1", Stall); end
        @(negedge clk);
        @(posedge clk); #1;
        Reset = 1'b1;
        #1;
        tests_run++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin tests_failed++; $display("FAIL rstwait req/stall got %0b/%0b exp 0/0", mem_req, Stall); end
        tests_run++; if (RegWr_wb !== 1'b0 || Rd_wb !== 5'd0 || WbData_wb !== 32'h0) begin tests_failed++; $display("FAIL rstwait wb got %0b/%0d/%h exp 0/0/0", RegWr_wb, Rd_wb, WbData_wb); end
        clear_inputs();
        @(negedge clk);
        @(posedge clk); #1;
        Reset = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rstwait no_retry got %0b exp 0", mem_req); end
        set_mem(1, 32'h0000_4004, 2); RegWr_in = 1'b1; Rd_in = 5'd12;
        run_txn(0, 32'h0000_00F0, "post_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int lt;
        for (int i = 0; i < 80; i++) begin
            clear_inputs();
            a  = $urandom;
            lt = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) a = (lt == 0) ? a & 32'hFFFF_FFFC : a & 32'hFFFF_FFFE;
            set_mem($urandom_range(0, 2), a, lt);
            PC_Branch_in = $urandom; PC_Jump_in = $urandom;
            Jump_in = 1'($urandom); Less_in = 1'($urandom); Zero_in = 1'($urandom);
            Condition_in = 3'($urandom);
            Overflow_in = ($urandom_range(0, 7) == 0);
            RegWr_in = 1'($urandom); Rd_in = 5'($urandom); Store_data_in = $urandom;
            run_txn($urandom_range(0, 3), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_byte();
        test_store_half_wait();
        test_misaligned();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
